// File: rtl/fifo_stim_gen.sv
// On-chip stimulus engine for the synchronous FIFO: LFSR random traffic plus
// fill/drain, alternate and simultaneous directed modes, with start/done and stall.
module fifo_stim_gen #(
    parameter int          DATA_WIDTH = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter int          ITERATIONS = 5000,
    parameter int          CNT_WIDTH  = 16,
    parameter logic [31:0] SEED       = 32'h1ACE_B00C,
    parameter logic [8:0]  WR_THRESH  = 9'd179,
    parameter logic [8:0]  RD_THRESH  = 9'd77,
    parameter logic [8:0]  RST_THRESH = 9'd3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  stall,
    output logic                  dut_rst_n,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  iter_cnt
);

    localparam logic [31:0] POLY     = 32'h8020_0003;
    localparam logic [31:0] DAT_SEED = SEED ^ 32'hA5A5_5A5A;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] M_RANDOM = 2'd0;
    localparam logic [1:0] M_FILL   = 2'd1;
    localparam logic [1:0] M_ALT    = 2'd2;
    localparam logic [1:0] M_SIMUL  = 2'd3;

    localparam int                   BW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [BW-1:0]        BURST_LAST = BW'(FIFO_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] ITER_LAST  = CNT_WIDTH'(ITERATIONS);

    // Galois LFSR step, shifting right
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? POLY : 32'h0000_0000);
    endfunction

    logic [1:0]            state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [31:0]           ctl_q, ctl_d;
    logic [31:0]           dat_q, dat_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic                  drain_q, drain_d;
    logic [CNT_WIDTH-1:0]  iter_q, iter_d;
    logic                  rst_n_q, rst_n_d;
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  issue_s;

    // Next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        ctl_d   = ctl_q;
        dat_d   = dat_q;
        burst_d = burst_q;
        drain_d = drain_q;
        iter_d  = iter_q;
        rst_n_d = rst_n_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;
        issue_s = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                wr_d = 1'b0;
                rd_d = 1'b0;
                if (start) begin
                    state_d = S_INIT;
                    mode_d  = mode;
                    iter_d  = '0;
                    ctl_d   = SEED;
                    dat_d   = DAT_SEED;
                    burst_d = '0;
                    drain_d = 1'b0;
                    rst_n_d = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end else begin
                    rst_n_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = (state_q == S_DONE);
                end
            end
            S_INIT: begin
                // vector 0 leaves on the edge that ends the DUT reset pulse
                state_d = S_RUN;
                issue_s = 1'b1;
            end
            S_RUN: begin
                if (stall) begin
                    wr_d    = 1'b0;
                    rd_d    = 1'b0;
                    rst_n_d = 1'b1;
                end else if (iter_q == ITER_LAST) begin
                    state_d = S_DONE;
                    wr_d    = 1'b0;
                    rd_d    = 1'b0;
                    rst_n_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    issue_s = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue_s) begin
            case (mode_q)
                M_RANDOM: begin
                    wr_d    = ({1'b0, ctl_q[7:0]} < WR_THRESH);
                    rd_d    = ({1'b0, ctl_q[15:8]} < RD_THRESH);
                    rst_n_d = !({1'b0, ctl_q[23:16]} < RST_THRESH);
                end
                M_FILL: begin
                    wr_d    = !drain_q;
                    rd_d    = drain_q;
                    rst_n_d = 1'b1;
                end
                M_ALT: begin
                    wr_d    = !iter_q[0];
                    rd_d    = iter_q[0];
                    rst_n_d = 1'b1;
                end
                M_SIMUL: begin
                    wr_d    = 1'b1;
                    rd_d    = 1'b1;
                    rst_n_d = 1'b1;
                end
                default: begin
                    wr_d    = 1'b0;
                    rd_d    = 1'b0;
                    rst_n_d = 1'b1;
                end
            endcase
            data_d = dat_q[DATA_WIDTH-1:0];
            ctl_d  = lfsr_next(ctl_q);
            dat_d  = lfsr_next(dat_q);
            iter_d = iter_q + CNT_WIDTH'(1);
            if (burst_q == BURST_LAST) begin
                burst_d = '0;
                drain_d = !drain_q;
            end else begin
                burst_d = burst_q + BW'(1);
            end
        end else begin
            issue_s = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 2'd0;
            ctl_q   <= SEED;
            dat_q   <= DAT_SEED;
            burst_q <= '0;
            drain_q <= 1'b0;
            iter_q  <= '0;
            rst_n_q <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ctl_q   <= ctl_d;
            dat_q   <= dat_d;
            burst_q <= burst_d;
            drain_q <= drain_d;
            iter_q  <= iter_d;
            rst_n_q <= rst_n_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dut_rst_n = rst_n_q;
    assign wr_en     = wr_q;
    assign rd_en     = rd_q;
    assign data_in   = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign iter_cnt  = iter_q;

endmodule

// File: tb/tb_fifo_stim_gen.sv
// Bench for fifo_stim_gen: directed runs pinned by literals plus a randomized
// phase, all checked each cycle against a vector-index-based reference model.
module tb_fifo_stim_gen;

    localparam int          DW    = 16;
    localparam int          FD    = 4;
    localparam int          IT    = 16;
    localparam logic [31:0] SEED  = 32'h1ACE_B00C;
    localparam logic [31:0] DSEED = SEED ^ 32'hA5A5_5A5A;
    localparam int          WR_T  = 179;
    localparam int          RD_T  = 77;
    localparam int          RST_T = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic          stall;
    logic          dut_rst_n;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data_in;
    logic          busy;
    logic          done;
    logic [15:0]   iter_cnt;

    fifo_stim_gen #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .ITERATIONS(IT), .CNT_WIDTH(16),
        .SEED(SEED), .WR_THRESH(9'd179), .RD_THRESH(9'd77), .RST_THRESH(9'd3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .stall(stall),
        .dut_rst_n(dut_rst_n), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
        .busy(busy), .done(done), .iter_cnt(iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] lfsr_at(input logic [31:0] seed, input int k);
        logic [31:0] s;
        s = seed;
        for (int i = 0; i < k; i++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
        return s;
    endfunction

    function automatic logic vec_wr(input logic [1:0] md, input int k);
        logic [31:0] c;
        c = lfsr_at(SEED, k);
        case (md)
            2'd0:    return int'(c[7:0]) < WR_T;
            2'd1:    return ((k / FD) % 2) == 0;
            2'd2:    return (k % 2) == 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic vec_rd(input logic [1:0] md, input int k);
        logic [31:0] c;
        c = lfsr_at(SEED, k);
        case (md)
            2'd0:    return int'(c[15:8]) < RD_T;
            2'd1:    return ((k / FD) % 2) == 1;
            2'd2:    return (k % 2) == 1;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic vec_rn(input logic [1:0] md, input int k);
        logic [31:0] c;
        c = lfsr_at(SEED, k);
        if (md == 2'd0) return !(int'(c[23:16]) < RST_T);
        else return 1'b1;
    endfunction

    function automatic logic [DW-1:0] vec_data(input int k);
        logic [31:0] d;
        d = lfsr_at(DSEED, k);
        return d[DW-1:0];
    endfunction

    logic          e_rn, e_wr, e_rd, e_busy, e_done;
    logic [DW-1:0] e_data;
    logic [15:0]   e_cnt;
    int            m_ph;   // 0 idle, 1 reset pulse, 2 running, 3 finished
    int            m_k;
    logic [1:0]    m_mode;

    always @(posedge clk) begin
        if (rst) begin
            e_rn <= 1'b0; e_wr <= 1'b0; e_rd <= 1'b0; e_data <= '0;
            e_busy <= 1'b0; e_done <= 1'b0; e_cnt <= 16'd0;
            m_ph <= 0; m_k <= 0; m_mode <= 2'd0;
        end else if (m_ph == 0 || m_ph == 3) begin
            e_wr <= 1'b0; e_rd <= 1'b0;
            if (start) begin
                m_mode <= mode; m_k <= 0; e_cnt <= 16'd0; m_ph <= 1;
                e_rn <= 1'b0; e_busy <= 1'b1; e_done <= 1'b0;
            end else begin
                e_rn <= 1'b1; e_busy <= 1'b0; e_done <= (m_ph == 3);
            end
        end else if (m_ph == 2 && stall) begin
            e_wr <= 1'b0; e_rd <= 1'b0; e_rn <= 1'b1;
        end else if (m_ph == 2 && m_k == IT) begin
            m_ph <= 3; e_wr <= 1'b0; e_rd <= 1'b0; e_rn <= 1'b1;
            e_busy <= 1'b0; e_done <= 1'b1;
        end else begin
            m_ph   <= 2;
            e_wr   <= vec_wr(m_mode, m_k);
            e_rd   <= vec_rd(m_mode, m_k);
            e_rn   <= vec_rn(m_mode, m_k);
            e_data <= vec_data(m_k);
            m_k    <= m_k + 1;
            e_cnt  <= 16'(m_k + 1);
        end
    end

    // every-cycle comparison against the model
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("dut_rst_n", 32'(dut_rst_n), 32'(e_rn));
            chk("wr_en",     32'(wr_en),     32'(e_wr));
            chk("rd_en",     32'(rd_en),     32'(e_rd));
            chk("data_in",   32'(data_in),   32'(e_data));
            chk("busy",      32'(busy),      32'(e_busy));
            chk("done",      32'(done),      32'(e_done));
            chk("iter_cnt",  32'(iter_cnt),  32'(e_cnt));
        end
    end

    // ---------------- directed runs ----------------
    logic          rec_wr[64], rec_rd[64], rec_rn[64], rec_busy[64];
    logic [DW-1:0] rec_data[64];
    logic [15:0]   rec_cnt[64];
    logic [DW-1:0] ref_data[IT];
    int            done_c;

    task automatic run(input logic [1:0] md, input int stall_from, input int stall_len,
                       input int rst_at, input int start_at);
        int c;
        @(negedge clk);
        mode = md; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0; done_c = -1;
        while (c < 64) begin
            rec_wr[c] = wr_en; rec_rd[c] = rd_en; rec_rn[c] = dut_rst_n;
            rec_busy[c] = busy; rec_data[c] = data_in; rec_cnt[c] = iter_cnt;
            if (done) begin done_c = c; break; end
            if (rst_at >= 0 && c == rst_at + 1) break;
            stall = (c >= stall_from) && (c < stall_from + stall_len);
            rst   = (c == rst_at);
            start = (c == start_at);
            @(negedge clk);
            c++;
        end
        stall = 1'b0; rst = 1'b0; start = 1'b0;
        if (rst_at < 0 && done_c < 0) chk("run_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [15:0] wpat, rpat;
        int          both;
        rst = 1'b1; start = 1'b0; mode = 2'd0; stall = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rst_n", 32'(dut_rst_n), 32'd0);
        chk("reset_busy",  32'(busy),      32'd0);
        chk("reset_cnt",   32'(iter_cnt),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rst_n", 32'(dut_rst_n), 32'd1);

        // SIMUL: one-cycle DUT reset, 16 write+read vectors, done 17 edges after start
        run(2'd3, -1, 0, -1, -1);
        chk("simul_init_rst_n", 32'(rec_rn[0]), 32'd0);
        chk("simul_init_busy",  32'(rec_busy[0]), 32'd1);
        chk("simul_v0_rst_n",   32'(rec_rn[1]), 32'd1);
        both = 0;
        for (int i = 1; i <= IT; i++) both += (rec_wr[i] && rec_rd[i]) ? 1 : 0;
        chk("simul_both_cnt", 32'(both), 32'd16);
        chk("simul_done_at",  32'(done_c), 32'd17);
        if (done_c >= 0) chk("simul_final_cnt", 32'(rec_cnt[done_c]), 32'd16);

        // FILL_DRAIN with depth 4
        run(2'd1, -1, 0, -1, -1);
        wpat = 16'd0; rpat = 16'd0;
        for (int i = 1; i <= IT; i++) begin
            wpat = {wpat[14:0], rec_wr[i]};
            rpat = {rpat[14:0], rec_rd[i]};
        end
        chk("fill_wr_pattern", 32'(wpat), 32'h0000_F0F0);
        chk("fill_rd_pattern", 32'(rpat), 32'h0000_0F0F);

        // RANDOM: first vectors pinned by hand-computed LFSR values
        run(2'd0, -1, 0, -1, -1);
        chk("rand_v0_data",  32'(rec_data[1]), 32'h0000_EA56);
        chk("rand_v1_data",  32'(rec_data[2]), 32'h0000_F52B);
        chk("rand_v0_wr",    32'(rec_wr[1]),   32'd1);
        chk("rand_v0_rd",    32'(rec_rd[1]),   32'd0);
        chk("rand_v0_rst_n", 32'(rec_rn[1]),   32'd1);
        for (int i = 0; i < IT; i++) ref_data[i] = rec_data[i + 1];

        run(2'd0, -1, 0, -1, -1);
        for (int i = 0; i < IT; i++) chk("rand_repeat", 32'(rec_data[i + 1]), 32'(ref_data[i]));

        // ALTERNATE with 3 stalled cycles after vector 2
        run(2'd2, 3, 3, -1, -1);
        for (int i = 4; i <= 6; i++) chk("alt_stall_idle", 32'({rec_wr[i], rec_rd[i]}), 32'd0);
        chk("alt_v3_wr",   32'(rec_wr[7]), 32'd0);
        chk("alt_v3_rd",   32'(rec_rd[7]), 32'd1);
        chk("alt_done_at", 32'(done_c),    32'd20);

        // mid-run start ignored, then abort by rst, then identical replay
        run(2'd0, -1, 0, 8, 4);
        chk("abort_rst_n", 32'(rec_rn[9]),   32'd0);
        chk("abort_busy",  32'(rec_busy[9]), 32'd0);
        chk("abort_data",  32'(rec_data[9]), 32'd0);
        chk("abort_cnt",   32'(rec_cnt[9]),  32'd0);
        run(2'd0, -1, 0, -1, -1);
        for (int i = 0; i < IT; i++) chk("replay_data", 32'(rec_data[i + 1]), 32'(ref_data[i]));

        // randomized phase, model-checked every cycle
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(199) == 0);
            start = ($urandom_range(7) == 0);
            mode  = 2'($urandom_range(3));
            stall = ($urandom_range(4) == 0);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
